// File: rtl/ram_pattern_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_pattern_sequencer_pkg
// Description : Shared constants for the RAM-backed LED pattern sequencer:
//               one-hot FSM state encodings, i_enable bit positions and the
//               preload pattern function used while the pattern RAM is filled.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_pattern_sequencer_pkg;

    // One-hot state encodings; the state register drives o_led_r directly.
    localparam logic [3:0] c_st_init  = 4'b0001;
    localparam logic [3:0] c_st_idle  = 4'b0010;
    localparam logic [3:0] c_st_run   = 4'b0100;
    localparam logic [3:0] c_st_pause = 4'b1000;

    // Bit positions inside i_enable.
    localparam int c_en_run    = 0;
    localparam int c_en_spd_lo = 1;
    localparam int c_en_spd_hi = 2;
    localparam int c_en_dir    = 3;

    // Preload word for entry idx: a single lit LED walking across the bar.
    function automatic int unsigned preload_word(input int unsigned idx,
                                                 input int unsigned nb_leds);
        return 32'd1 << (idx % nb_leds);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_pattern_sequencer_dpram.sv
`default_nettype none
// ============================================================================
// Module      : ram_pattern_sequencer_dpram
// Description : Pattern RAM, NB_DATA x DEPTH. One write port, one registered
//               read port, write-first when both ports hit the same address.
// Ports       : clk      - system clock
//               rst      - synchronous active-high reset (clears read data)
//               i_we     - write strobe (address already range-checked)
//               i_waddr  - write address
//               i_wdata  - write data
//               i_rd_clr - force the read register to zero this cycle
//               i_raddr  - read address
//               o_rdata  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module ram_pattern_sequencer_dpram #(
    parameter int unsigned NB_DATA = 4,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned NB_ADDR = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_we,
    input  logic [NB_ADDR-1:0] i_waddr,
    input  logic [NB_DATA-1:0] i_wdata,
    input  logic               i_rd_clr,
    input  logic [NB_ADDR-1:0] i_raddr,
    output logic [NB_DATA-1:0] o_rdata
);

    // Only the low bits needed to address DEPTH entries index the array;
    // the caller guarantees both addresses stay below DEPTH.
    localparam int unsigned c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NB_DATA-1:0] r_mem [DEPTH];
    logic [c_idx_w-1:0] w_widx;
    logic [c_idx_w-1:0] w_ridx;
    logic               w_collide;

    assign w_widx    = i_waddr[c_idx_w-1:0];
    assign w_ridx    = i_raddr[c_idx_w-1:0];
    assign w_collide = i_we && (i_waddr == i_raddr);

    // Memory array carries no reset so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[w_widx] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_rd_clr) begin
            o_rdata <= '0;
        end else if (w_collide) begin
            o_rdata <= i_wdata;
        end else begin
            o_rdata <= r_mem[w_ridx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ram_pattern_sequencer
// Description : RAM-backed LED pattern player. After reset the FSM preloads
//               the pattern RAM, then a read pointer steps through it at one
//               of four prescaled rates in either direction. A host write
//               port edits patterns live.
// Ports       : clock     - system clock
//               i_reset   - synchronous active-high reset
//               i_enable  - [0] run, [2:1] speed select, [3] direction (1=down)
//               i_wr_en   - host write strobe
//               i_wr_addr - host write address (>= RAM_DEPTH ignored)
//               i_wr_data - host write data
//               o_leds    - current pattern word
//               o_led_r   - one-hot FSM state {PAUSE,RUN,IDLE,INIT}
//               o_addr    - current read pointer
// Revision    : 1.0 - initial release
// ============================================================================
module ram_pattern_sequencer
    import ram_pattern_sequencer_pkg::*;
#(
    parameter int unsigned NB_LEDS   = 4,
    parameter int unsigned RAM_DEPTH = 16,
    parameter int unsigned NB_ADDR   = 4,
    parameter int unsigned NB_COUNT  = 32,
    parameter int unsigned COUNT0    = 25_000_000,
    parameter int unsigned COUNT1    = 12_500_000,
    parameter int unsigned COUNT2    = 6_250_000,
    parameter int unsigned COUNT3    = 3_125_000
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic [3:0]         i_enable,
    input  logic               i_wr_en,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_LEDS-1:0] i_wr_data,
    output logic [NB_LEDS-1:0] o_leds,
    output logic [3:0]         o_led_r,
    output logic [NB_ADDR-1:0] o_addr
);

    localparam logic [NB_ADDR-1:0]  c_last_addr = NB_ADDR'(RAM_DEPTH - 1);
    localparam logic [NB_ADDR-1:0]  c_one_addr  = NB_ADDR'(1);
    localparam logic [NB_COUNT-1:0] c_one_cnt   = NB_COUNT'(1);
    localparam logic [NB_COUNT-1:0] c_lim0_m1   = NB_COUNT'(COUNT0 - 1);
    localparam logic [NB_COUNT-1:0] c_lim1_m1   = NB_COUNT'(COUNT1 - 1);
    localparam logic [NB_COUNT-1:0] c_lim2_m1   = NB_COUNT'(COUNT2 - 1);
    localparam logic [NB_COUNT-1:0] c_lim3_m1   = NB_COUNT'(COUNT3 - 1);

    logic [3:0]          r_state;
    logic [3:0]          w_state_nxt;
    logic [NB_COUNT-1:0] r_presc;
    logic [NB_COUNT-1:0] w_limit_m1;
    logic [NB_ADDR-1:0]  r_addr;
    logic [NB_ADDR-1:0]  w_addr_step;
    logic [NB_ADDR-1:0]  r_init_idx;
    logic [1:0]          r_speed_prev;
    logic [1:0]          w_speed;
    logic                w_run;
    logic                w_dir;
    logic                w_speed_chg;
    logic                w_presc_wrap;
    logic                w_tick;
    logic                w_init_last;
    logic                w_in_init;
    logic                w_host_wr;
    logic                w_we;
    logic                w_rd_clr;
    logic [NB_ADDR-1:0]  w_waddr;
    logic [NB_LEDS-1:0]  w_wdata;

    assign w_run   = i_enable[c_en_run];
    assign w_dir   = i_enable[c_en_dir];
    assign w_speed = i_enable[c_en_spd_hi:c_en_spd_lo];

    // Speed select is compared with last cycle's value so any edit restarts
    // the prescaler from zero instead of carrying a stale count across rates.
    assign w_speed_chg  = (w_speed != r_speed_prev);
    assign w_presc_wrap = (r_presc == w_limit_m1);
    assign w_tick       = (r_state == c_st_run) && !w_speed_chg && w_presc_wrap;
    assign w_init_last  = (r_init_idx == c_last_addr);
    assign w_in_init    = (r_state == c_st_init);

    always_comb begin
        w_limit_m1 = c_lim0_m1;
        case (w_speed)
            2'b00:   w_limit_m1 = c_lim0_m1;
            2'b01:   w_limit_m1 = c_lim1_m1;
            2'b10:   w_limit_m1 = c_lim2_m1;
            default: w_limit_m1 = c_lim3_m1;
        endcase
    end

    // Pointer step with wrap in both directions (RAM_DEPTH need not be 2^n).
    always_comb begin
        w_addr_step = r_addr;
        if (w_dir) begin
            w_addr_step = (r_addr == '0) ? c_last_addr : (r_addr - c_one_addr);
        end else begin
            w_addr_step = (r_addr == c_last_addr) ? '0 : (r_addr + c_one_addr);
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_state <= c_st_init;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_init: begin
                if (w_init_last) begin
                    w_state_nxt = w_run ? c_st_run : c_st_idle;
                end
            end
            c_st_idle: begin
                if (w_run) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                if (!w_run) begin
                    w_state_nxt = c_st_pause;
                end
            end
            c_st_pause: begin
                if (w_run) begin
                    w_state_nxt = c_st_run;
                end
            end
            default: w_state_nxt = c_st_init;
        endcase
    end

    // ------------------------------------------------------------------------
    // Prescaler, read pointer and preload index
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_presc      <= '0;
            r_addr       <= '0;
            r_init_idx   <= '0;
            r_speed_prev <= '0;
        end else begin
            r_speed_prev <= w_speed;
            case (r_state)
                c_st_init: begin
                    r_init_idx <= w_init_last ? '0 : (r_init_idx + c_one_addr);
                    r_presc    <= '0;
                    r_addr     <= '0;
                end
                c_st_run: begin
                    // The edge that leaves RUN still counts; PAUSE then
                    // freezes whatever value this edge produced.
                    if (w_speed_chg || w_presc_wrap) begin
                        r_presc <= '0;
                    end else begin
                        r_presc <= r_presc + c_one_cnt;
                    end
                    if (w_tick) begin
                        r_addr <= w_addr_step;
                    end
                end
                c_st_pause: begin
                    if (w_speed_chg) begin
                        r_presc <= '0;
                    end
                end
                default: begin
                    r_presc <= '0;
                    r_addr  <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Pattern RAM: the preload owns the write port during INIT, the host
    // owns it otherwise. Out-of-range host addresses are dropped here.
    // ------------------------------------------------------------------------
    assign w_host_wr = i_wr_en && (i_wr_addr <= c_last_addr) && !w_in_init;
    assign w_we      = !i_reset && (w_in_init || w_host_wr);
    assign w_waddr   = w_in_init ? r_init_idx : i_wr_addr;
    assign w_wdata   = w_in_init ? NB_LEDS'(preload_word(32'(r_init_idx), NB_LEDS))
                                 : i_wr_data;
    assign w_rd_clr  = w_in_init || (r_state == c_st_idle);

    ram_pattern_sequencer_dpram #(
        .NB_DATA (NB_LEDS),
        .DEPTH   (RAM_DEPTH),
        .NB_ADDR (NB_ADDR)
    ) u_dpram (
        .clk      (clock),
        .rst      (i_reset),
        .i_we     (w_we),
        .i_waddr  (w_waddr),
        .i_wdata  (w_wdata),
        .i_rd_clr (w_rd_clr),
        .i_raddr  (r_addr),
        .o_rdata  (o_leds)
    );

    assign o_addr  = r_addr;
    assign o_led_r = r_state;

endmodule
`default_nettype wire
